// File: rtl/ipsmacge_txpause_if.sv
// TX pause-frame handshake between the pause generator and the TX arbiter.
interface ipsmacge_txpause_if;
    logic       txpreq;
    logic       txpgnt;
    logic [7:0] txpdat;
    logic       txpvld;
    logic       txpsof;
    logic       txpeof;
    logic       opausent;

    modport master (
        output txpreq, txpdat, txpvld, txpsof, txpeof, opausent,
        input  txpgnt
    );

    modport slave (
        input  txpreq, txpdat, txpvld, txpsof, txpeof, opausent,
        output txpgnt
    );
endinterface

// File: rtl/ipsmacge_txpause.sv
// IEEE 802.3x PAUSE frame generator for the GE MAC transmit path.
// Emits a 60-byte MAC control frame (no preamble/FCS) on an RX FIFO
// watermark request, with periodic XOFF refresh while the request holds.
// Optional build macro IPSMACGE_TXPAUSE_XON_EN adds XON (quanta 0) frames
// on the falling edge of the request.
module ipsmacge_txpause (
    input  logic        maclk,
    input  logic        marst_,
    input  logic        pauen,
    input  logic        pausreq,
    input  logic [15:0] pauquacfg,
    input  logic [15:0] pwrefresh,
    input  logic [47:0] srcmac,
    ipsmacge_txpause_if.master tx
);
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned REFR_W   = 22;
    localparam int unsigned LAST_IDX = 59;

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [47:0]        sa_q;
    logic [15:0]        quanta_q;
    logic               is_xoff;
    logic               xoff_pend;
    logic               xon_pend;
    logic               req_q;
    logic               armed;
    logic [REFR_W-1:0]  refr_cnt;
    logic               refr_on;

    logic               rise;
    logic               refr_stop;
    logic               refr_hit;
    logic               refr_load;
    logic               take;
    logic               sel_xoff;
    logic               last;
`ifdef IPSMACGE_TXPAUSE_XON_EN
    logic               fall;
    logic               xoff_sent;
`endif

    // Byte i of the frame for the latched source MAC and quanta.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i,
                                              input logic [47:0] sa,
                                              input logic [15:0] q);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            6'd0:  b = 8'h01;
            6'd1:  b = 8'h80;
            6'd2:  b = 8'hC2;
            6'd5:  b = 8'h01;
            6'd6:  b = sa[47:40];
            6'd7:  b = sa[39:32];
            6'd8:  b = sa[31:24];
            6'd9:  b = sa[23:16];
            6'd10: b = sa[15:8];
            6'd11: b = sa[7:0];
            6'd12: b = 8'h88;
            6'd13: b = 8'h08;
            6'd15: b = 8'h01;
            6'd16: b = q[15:8];
            6'd17: b = q[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Edge detection; 'armed' keeps a request already high at reset release from counting as an edge.
    assign rise      = armed & pausreq & ~req_q;
`ifdef IPSMACGE_TXPAUSE_XON_EN
    assign fall      = armed & ~pausreq & req_q;
`endif
    assign refr_stop = ~pausreq | ~pauen;
    assign refr_hit  = refr_on & (refr_cnt == REFR_W'(1)) & ~refr_stop;
    assign last      = (idx == IDX_W'(LAST_IDX));
    assign refr_load = (state == SEND) & (idx == IDX_W'(LAST_IDX - 1)) & is_xoff
                     & pausreq & pauen & (pwrefresh != 16'h0000);
    assign take      = (state == REQ) & pauen & tx.txpgnt;
    assign sel_xoff  = xoff_pend | ~xon_pend;

    // Request edge register.
    always_ff @(posedge maclk or negedge marst_) begin
        if (!marst_) begin
            req_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            req_q <= pausreq;
            armed <= 1'b1;
        end
    end

    // Refresh countdown; loaded as the XOFF frame's last byte goes out.
    always_ff @(posedge maclk or negedge marst_) begin
        if (!marst_) begin
            refr_on  <= 1'b0;
            refr_cnt <= '0;
        end else if (refr_stop) begin
            refr_on  <= 1'b0;
            refr_cnt <= '0;
        end else if (refr_load) begin
            refr_on  <= 1'b1;
            refr_cnt <= {pwrefresh, 6'b000000};
        end else if (refr_on) begin
            refr_cnt <= refr_cnt - REFR_W'(1);
            if (refr_cnt == REFR_W'(1)) begin
                refr_on <= 1'b0;
            end
        end
    end

    // Frame FSM, pending flags and registered frame outputs.
    always_ff @(posedge maclk or negedge marst_) begin
        if (!marst_) begin
            state       <= IDLE;
            idx         <= '0;
            sa_q        <= '0;
            quanta_q    <= '0;
            is_xoff     <= 1'b0;
            xoff_pend   <= 1'b0;
            xon_pend    <= 1'b0;
            tx.txpreq   <= 1'b0;
            tx.txpdat   <= 8'h00;
            tx.txpvld   <= 1'b0;
            tx.txpsof   <= 1'b0;
            tx.txpeof   <= 1'b0;
            tx.opausent <= 1'b0;
`ifdef IPSMACGE_TXPAUSE_XON_EN
            xoff_sent   <= 1'b0;
`endif
        end else begin
            // A new trigger of one kind cancels the other; grant consumes both (merge).
            if (!pauen) begin
                xoff_pend <= 1'b0;
                xon_pend  <= 1'b0;
            end else if (rise || refr_hit) begin
                xoff_pend <= 1'b1;
                xon_pend  <= 1'b0;
`ifdef IPSMACGE_TXPAUSE_XON_EN
            end else if (fall && xoff_sent) begin
                xon_pend  <= 1'b1;
                xoff_pend <= 1'b0;
`endif
            end else if (take) begin
                xoff_pend <= 1'b0;
                xon_pend  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pauen && (xoff_pend || xon_pend || refr_hit)) begin
                        state     <= REQ;
                        tx.txpreq <= 1'b1;
                    end
                end
                REQ: begin
                    if (!pauen) begin
                        state     <= IDLE;
                        tx.txpreq <= 1'b0;
                    end else if (tx.txpgnt) begin
                        state     <= SEND;
                        tx.txpreq <= 1'b0;
                        idx       <= '0;
                        sa_q      <= srcmac;
                        quanta_q  <= sel_xoff ? pauquacfg : 16'h0000;
                        is_xoff   <= sel_xoff;
`ifdef IPSMACGE_TXPAUSE_XON_EN
                        xoff_sent <= sel_xoff;
`endif
                        tx.txpdat <= frame_byte(IDX_W'(0), srcmac, pauquacfg);
                        tx.txpvld <= 1'b1;
                        tx.txpsof <= 1'b1;
                    end
                end
                SEND: begin
                    if (last) begin
                        state       <= IDLE;
                        idx         <= '0;
                        tx.txpdat   <= 8'h00;
                        tx.txpvld   <= 1'b0;
                        tx.txpeof   <= 1'b0;
                        tx.opausent <= 1'b0;
                    end else begin
                        idx         <= idx + IDX_W'(1);
                        tx.txpdat   <= frame_byte(idx + IDX_W'(1), sa_q, quanta_q);
                        tx.txpsof   <= 1'b0;
                        tx.txpeof   <= (idx == IDX_W'(LAST_IDX - 1));
                        tx.opausent <= (idx == IDX_W'(LAST_IDX - 1));
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx.txpreq <= 1'b0;
                    tx.txpvld <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ipsmacge_txpause.sv
// Self-checking bench for ipsmacge_txpause: randomized frame contents and
// grant delays against a frame-level reference (packed frame image, expected
// latencies, XOFF/XON bookkeeping).
module tb_ipsmacge_txpause;
    localparam int unsigned FRAME_LEN = 60;

    logic        maclk = 1'b0;
    logic        marst_;
    logic        pauen;
    logic        pausreq;
    logic [15:0] pauquacfg;
    logic [15:0] pwrefresh;
    logic [47:0] srcmac;

    int errors = 0;
    int checks = 0;
    bit xoff_since_xon = 1'b0;

    ipsmacge_txpause_if tx();

    ipsmacge_txpause dut (
        .maclk     (maclk),
        .marst_    (marst_),
        .pauen     (pauen),
        .pausreq   (pausreq),
        .pauquacfg (pauquacfg),
        .pwrefresh (pwrefresh),
        .srcmac    (srcmac),
        .tx        (tx)
    );

    always #5 maclk = ~maclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: whole frame image, byte i taken MSB first.
    function automatic logic [7:0] ref_byte(input int i, input logic [47:0] sa, input logic [15:0] q);
        logic [479:0] f;
        f = {48'h0180C2000001, sa, 16'h8808, 16'h0001, q, 336'h0};
        return f[479 - 8*i -: 8];
    endfunction

    task automatic wait_req(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (tx.txpreq !== 1'b1 && n < 400) begin
            @(negedge maclk);
            n++;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int busy;
        busy = 0;
        repeat (cycles) begin
            @(negedge maclk);
            if (tx.txpreq !== 1'b0 || tx.txpvld !== 1'b0) busy++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    // Grant after gdly cycles and check all 60 bytes; optional request toggle or reset abort.
    task automatic do_frame(input string tag, input int gdly, input bit is_xon,
                            input int toggle_at, input int abort_at);
        logic [47:0] sa;
        logic [15:0] qcfg;
        logic [15:0] q;
        logic [12:0] exp_v;
        bit aborted;
        aborted = 1'b0;
        repeat (gdly) @(negedge maclk);
        chk({tag, " req held"}, 64'(tx.txpreq), 64'd1);
        sa   = srcmac;
        qcfg = pauquacfg;
        q    = is_xon ? 16'h0000 : pauquacfg;
        tx.txpgnt = 1'b1;
        @(negedge maclk);
        tx.txpgnt = 1'b0;
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            exp_v = {1'b0, 1'b1, (i == 0), (i == 59), (i == 59), ref_byte(i, sa, q)};
            chk($sformatf("%s byte%0d", tag, i),
                64'({tx.txpreq, tx.txpvld, tx.txpsof, tx.txpeof, tx.opausent, tx.txpdat}),
                64'(exp_v));
            if (toggle_at >= 0 && i == toggle_at)      pausreq = 1'b0;
            if (toggle_at >= 0 && i == toggle_at + 10) pausreq = 1'b1;
            if (i == abort_at) begin
                marst_ = 1'b0;
                @(posedge maclk);
                #1;
                chk({tag, " reset outs"},
                    64'({tx.txpreq, tx.txpvld, tx.txpsof, tx.txpeof, tx.opausent, tx.txpdat}),
                    64'd0);
                aborted = 1'b1;
                break;
            end
            srcmac    = {16'($urandom), $urandom};
            pauquacfg = 16'($urandom);
            if (i < int'(FRAME_LEN) - 1) @(negedge maclk);
        end
        srcmac    = sa;
        pauquacfg = qcfg;
        if (aborted)     xoff_since_xon = 1'b0;
        else if (is_xon) xoff_since_xon = 1'b0;
        else             xoff_since_xon = 1'b1;
    endtask

    // Drop the request; XON only when built in and an XOFF went out since the last XON.
    task automatic drop_req(input string tag);
        pausreq = 1'b0;
`ifdef IPSMACGE_TXPAUSE_XON_EN
        if (xoff_since_xon && pauen) begin
            wait_req({tag, " xon req"}, 2);
            do_frame({tag, " xon"}, int'($urandom_range(0, 3)), 1'b1, -1, -1);
            @(negedge maclk);
            quiet({tag, " after xon"}, 20);
        end else begin
            quiet({tag, " no xon"}, 30);
        end
`else
        quiet({tag, " no xon"}, 30);
`endif
    endtask

    initial begin
        int rf;
        marst_    = 1'b0;
        pauen     = 1'b0;
        pausreq   = 1'b0;
        pauquacfg = 16'h0000;
        pwrefresh = 16'h0000;
        srcmac    = 48'h0;
        tx.txpgnt = 1'b0;
        repeat (3) @(negedge maclk);
        chk("reset outs",
            64'({tx.txpreq, tx.txpvld, tx.txpsof, tx.txpeof, tx.opausent, tx.txpdat}), 64'd0);
        marst_ = 1'b1;
        pauen  = 1'b1;
        @(negedge maclk);

        // Basic XOFF frame, grant three cycles after request.
        pauquacfg = 16'h00FF;
        srcmac    = 48'h001122334455;
        pausreq   = 1'b1;
        wait_req("xoff req lat", 2);
        do_frame("xoff", 3, 1'b0, -1, -1);
        @(negedge maclk);
        chk("after eof", 64'({tx.txpvld, tx.txpreq, tx.opausent}), 64'd0);
        quiet("no refresh", 30);
        drop_req("basic");

        // Randomized contents, grant delays, stray grants while idle.
        for (int k = 0; k < 5; k++) begin
            pauquacfg = 16'($urandom);
            srcmac    = {16'($urandom), $urandom};
            tx.txpgnt = 1'b1;
            @(negedge maclk);
            tx.txpgnt = 1'b0;
            chk($sformatf("stray grant %0d", k), 64'({tx.txpvld, tx.txpreq}), 64'd0);
            pausreq = 1'b1;
            wait_req($sformatf("rnd req %0d", k), 2);
            do_frame($sformatf("rnd%0d", k), int'($urandom_range(0, 5)), 1'b0, -1, -1);
            @(negedge maclk);
            drop_req($sformatf("rnd%0d", k));
        end

        // Refresh: fixed 2 units then two random intervals; second frame identical.
        for (int k = 0; k < 3; k++) begin
            rf = (k == 0) ? 2 : int'($urandom_range(1, 3));
            pwrefresh = 16'(rf);
            pausreq   = 1'b1;
            wait_req($sformatf("refr%0d req", k), 2);
            do_frame($sformatf("refr%0d first", k), 1, 1'b0, -1, -1);
            wait_req($sformatf("refr%0d gap", k), rf * 64);
            do_frame($sformatf("refr%0d second", k), 0, 1'b0, -1, -1);
            drop_req($sformatf("refr%0d", k));
            pwrefresh = 16'h0000;
        end

        // Request toggling during SEND merges into exactly one extra frame.
        pausreq = 1'b1;
        wait_req("toggle req", 2);
        do_frame("toggle", 2, 1'b0, 10, -1);
        wait_req("extra req", 2);
        do_frame("extra", 1, 1'b0, -1, -1);
        quiet("no third", 100);
        drop_req("toggle");

        // Reset at byte 30 aborts; no resume; needs a fresh edge.
        pausreq = 1'b1;
        wait_req("abort req", 2);
        do_frame("abort", 1, 1'b0, -1, 30);
        @(negedge maclk);
        marst_ = 1'b1;
        quiet("no resume", 100);
        drop_req("post reset");
        pausreq = 1'b1;
        wait_req("fresh req", 2);
        do_frame("fresh", 2, 1'b0, -1, -1);
        @(negedge maclk);
        drop_req("fresh");

        // pauen falling in REQ drops request; later grant ignored.
        pausreq = 1'b1;
        wait_req("pauen req", 2);
        pauen = 1'b0;
        @(negedge maclk);
        chk("pauen drop req", 64'(tx.txpreq), 64'd0);
        tx.txpgnt = 1'b1;
        @(negedge maclk);
        tx.txpgnt = 1'b0;
        chk("late grant vld", 64'(tx.txpvld), 64'd0);
        quiet("late grant", 10);
        pauen = 1'b1;
        quiet("pend cleared", 30);
        drop_req("pauen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
